// File: rtl/fir_seq_ctrl.sv
// Sequencer between coefficient/sample streams and a PCPI FIR accelerator.
// It loads N*K coefficients through LOADH, then issues one CALCULATE per sample.
module fir_seq_ctrl #(
    parameter int unsigned N       = 8,
    parameter int unsigned K       = 256,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cfg_start,
    input  logic        run_en,
    input  logic        coef_valid,
    output logic        coef_ready,
    input  logic [31:0] coef_data,
    input  logic        smp_valid,
    output logic        smp_ready,
    input  logic [31:0] smp_rs1,
    input  logic [31:0] smp_rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_ready,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    output logic        coef_loaded,
    output logic        err
);

    localparam int unsigned AS_W = (N > 16) ? $clog2(N) : 4;
    localparam int unsigned K_W  = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [31:0] INSN_LOADH = 32'h0000_3027;
    localparam logic [31:0] INSN_CALC  = 32'h0000_2027;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CMD,
        S_GAP,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [AS_W-1:0]   as_idx_q, as_idx_d;
    logic [K_W-1:0]    k_idx_q, k_idx_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              loading_q, loading_d;
    logic              last_q, last_d;
    logic              coef_loaded_q, coef_loaded_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [31:0]       insn_q, insn_d;
    logic [31:0]       rs1_q, rs1_d;
    logic [31:0]       rs2_q, rs2_d;
    logic              pcpi_valid_q, pcpi_valid_d;
    logic              err_q, err_d;
    logic              coef_ready_c;
    logic              smp_ready_c;

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q       <= S_IDLE;
            as_idx_q      <= '0;
            k_idx_q       <= '0;
            to_cnt_q      <= '0;
            loading_q     <= 1'b0;
            last_q        <= 1'b0;
            coef_loaded_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            insn_q        <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            pcpi_valid_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            as_idx_q      <= as_idx_d;
            k_idx_q       <= k_idx_d;
            to_cnt_q      <= to_cnt_d;
            loading_q     <= loading_d;
            last_q        <= last_d;
            coef_loaded_q <= coef_loaded_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            insn_q        <= insn_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            pcpi_valid_q  <= pcpi_valid_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        as_idx_d      = as_idx_q;
        k_idx_d       = k_idx_q;
        to_cnt_d      = to_cnt_q;
        loading_d     = loading_q;
        last_d        = last_q;
        coef_loaded_d = coef_loaded_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        insn_d        = insn_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;

        coef_ready_c  = (state_q == S_LOAD);
        // A pending cfg_start blocks sample acceptance in the same cycle.
        smp_ready_c   = (state_q == S_IDLE) && !cfg_start && coef_loaded_q
                        && run_en && !out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    state_d       = S_LOAD;
                    as_idx_d      = '0;
                    k_idx_d       = '0;
                    loading_d     = 1'b1;
                    last_d        = 1'b0;
                    coef_loaded_d = 1'b0;
                end else if (smp_valid && smp_ready_c) begin
                    rs1_d    = smp_rs1;
                    rs2_d    = smp_rs2;
                    insn_d   = INSN_CALC;
                    to_cnt_d = '0;
                    state_d  = S_CMD;
                end
            end
            S_LOAD: begin
                if (coef_valid) begin
                    rs1_d    = coef_data;
                    rs2_d    = 32'(as_idx_q[3:0]);
                    insn_d   = INSN_LOADH;
                    to_cnt_d = '0;
                    state_d  = S_CMD;
                end
            end
            S_CMD: begin
                if (pcpi_ready) begin
                    if (insn_q == INSN_CALC) begin
                        if (pcpi_wr) begin
                            out_data_d  = pcpi_rd;
                            out_valid_d = 1'b1;
                            state_d     = S_GAP;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else begin
                        last_d = (as_idx_q == AS_W'(N - 1)) && (k_idx_q == K_W'(K - 1));
                        if (k_idx_q == K_W'(K - 1)) begin
                            k_idx_d  = '0;
                            as_idx_d = (as_idx_q == AS_W'(N - 1)) ? '0 : as_idx_q + AS_W'(1);
                        end else begin
                            k_idx_d = k_idx_q + K_W'(1);
                        end
                        state_d = S_GAP;
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_GAP: begin
                if (loading_q && last_q) begin
                    coef_loaded_d = 1'b1;
                    loading_d     = 1'b0;
                    state_d       = S_IDLE;
                end else if (loading_q) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase

        // Command strobe and error flag are registered decodes of the next state.
        pcpi_valid_d = (state_d == S_CMD);
        err_d        = (state_d == S_ERR);
    end

    assign coef_ready  = coef_ready_c;
    assign smp_ready   = smp_ready_c;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign pcpi_valid  = pcpi_valid_q;
    assign pcpi_insn   = insn_q;
    assign pcpi_rs1    = rs1_q;
    assign pcpi_rs2    = rs2_q;
    assign coef_loaded = coef_loaded_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl with N=3, K=4 and a two-cycle PCPI accelerator model.
module tb_fir_seq_ctrl;

    localparam int unsigned N       = 3;
    localparam int unsigned K       = 4;
    localparam int unsigned TIMEOUT = 15;
    localparam logic [31:0] LOADH   = 32'h0000_3027;
    localparam logic [31:0] CALC    = 32'h0000_2027;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cfg_start;
    logic        run_en;
    logic        coef_valid;
    logic        coef_ready;
    logic [31:0] coef_data;
    logic        smp_valid;
    logic        smp_ready;
    logic [31:0] smp_rs1;
    logic [31:0] smp_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_ready;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        coef_loaded;
    logic        err;

    logic        model_en;
    logic [31:0] model_rd;
    logic        acc_ready = 1'b0;

    logic [31:0] log_insn [256];
    logic [31:0] log_rs1  [256];
    logic [31:0] log_rs2  [256];
    int          log_n = 0;

    int checks = 0;
    int passed = 0;

    fir_seq_ctrl #(.N(N), .K(K), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .cfg_start(cfg_start), .run_en(run_en),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_rs1(smp_rs1), .smp_rs2(smp_rs2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1),
        .pcpi_rs2(pcpi_rs2), .pcpi_ready(pcpi_ready), .pcpi_wr(pcpi_wr),
        .pcpi_rd(pcpi_rd), .coef_loaded(coef_loaded), .err(err)
    );

    always #5 clk = ~clk;

    // Accelerator answers on the second cycle of each command.
    always @(posedge clk) begin
        if (resetn) acc_ready <= 1'b0;
        else        acc_ready <= pcpi_valid && !acc_ready && model_en;
    end
    assign pcpi_ready = acc_ready;
    assign pcpi_wr    = acc_ready;
    assign pcpi_rd    = model_rd;

    always @(posedge clk) begin
        if (!resetn && pcpi_valid && pcpi_ready) begin
            log_insn[log_n % 256] <= pcpi_insn;
            log_rs1[log_n % 256]  <= pcpi_rs1;
            log_rs2[log_n % 256]  <= pcpi_rs2;
            log_n                 <= log_n + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Streams coefficients 1,2,3,... until loaded, or until command stop_cmd is in flight.
    task automatic feed_coefs(input int stop_cmd, output int cycles);
        int   val;
        int   base;
        logic hs;
        val        = 1;
        base       = log_n;
        cycles     = 0;
        coef_valid = 1'b1;
        coef_data  = 32'd1;
        for (int c = 0; c < 300; c++) begin
            hs = coef_valid && coef_ready;
            step();
            cycles++;
            if (hs) begin
                val++;
                if (val > int'(N * K)) coef_valid = 1'b0;
                coef_data = 32'(val);
            end
            if (stop_cmd == 0 && coef_loaded) break;
            if (stop_cmd != 0 && pcpi_valid && (log_n - base) == stop_cmd - 1) break;
        end
        coef_valid = 1'b0;
    endtask

    task automatic do_load(input string tag);
        int          base;
        int          cyc;
        logic [95:0] got;
        logic [95:0] exp;
        base      = log_n;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        feed_coefs(0, cyc);
        checks++;
        if (cyc !== 48) $display("FAIL %s_cycles: got %0d expected 48", tag, cyc);
        else passed++;
        checks++;
        if (coef_loaded !== 1'b1 || coef_ready !== 1'b0)
            $display("FAIL %s_loaded: got loaded=%b ready=%b expected 1/0", tag, coef_loaded, coef_ready);
        else passed++;
        checks++;
        if (log_n - base !== 12) $display("FAIL %s_count: got %0d expected 12", tag, log_n - base);
        else passed++;
        for (int i = 0; i < 12; i++) begin
            exp = {LOADH, 32'(i + 1), 32'(i / 4)};
            got = {log_insn[(base + i) % 256], log_rs1[(base + i) % 256], log_rs2[(base + i) % 256]};
            checks++;
            if (got !== exp) $display("FAIL %s_cmd%0d: got %h expected %h", tag, i, got, exp);
            else passed++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        repeat (2) step();
        checks++;
        if ({pcpi_valid, out_valid, coef_loaded, err, coef_ready, smp_ready} !== 6'b0)
            $display("FAIL reset_flags: got %b expected 000000",
                     {pcpi_valid, out_valid, coef_loaded, err, coef_ready, smp_ready});
        else passed++;
        checks++;
        if ({pcpi_insn, pcpi_rs1, pcpi_rs2, out_data} !== 128'b0)
            $display("FAIL reset_words: got %h expected 0", {pcpi_insn, pcpi_rs1, pcpi_rs2, out_data});
        else passed++;
        resetn    = 1'b0;
        run_en    = 1'b1;
        smp_valid = 1'b1;
        step();
        checks++;
        if (smp_ready !== 1'b0 || pcpi_valid !== 1'b0)
            $display("FAIL reset_unloaded: got smp_ready=%b pcpi_valid=%b expected 0/0", smp_ready, pcpi_valid);
        else passed++;
        smp_valid = 1'b0;
    endtask

    task automatic test_load();
        do_load("load");
    endtask

    task automatic test_sample();
        model_rd  = 32'h1234;
        out_ready = 1'b0;
        smp_rs1   = 32'h155;
        smp_rs2   = 32'h2AA;
        smp_valid = 1'b1;
        #1;
        checks++;
        if (smp_ready !== 1'b1) $display("FAIL smp_accept: got %b expected 1", smp_ready);
        else passed++;
        step();
        smp_valid = 1'b0;
        checks++;
        if ({pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2} !== {1'b1, CALC, 32'h155, 32'h2AA})
            $display("FAIL smp_cmd: got %b %h %h %h expected 1 %h 155 2aa",
                     pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, CALC);
        else passed++;
        step();
        checks++;
        if (pcpi_valid !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL smp_t2: got pcpi_valid=%b out_valid=%b expected 1/0", pcpi_valid, out_valid);
        else passed++;
        step();
        checks++;
        if ({out_valid, out_data, pcpi_valid} !== {1'b1, 32'h1234, 1'b0})
            $display("FAIL smp_out: got %b %h %b expected 1 00001234 0", out_valid, out_data, pcpi_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        smp_valid = 1'b1;
        smp_rs1   = 32'h11;
        smp_rs2   = 32'h22;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({smp_ready, out_valid, out_data} !== {1'b0, 1'b1, 32'h1234})
                $display("FAIL bp_hold%0d: got %b %b %h expected 0 1 00001234", i, smp_ready, out_valid, out_data);
            else passed++;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        model_rd  = 32'h5678;
        checks++;
        if (out_valid !== 1'b0 || smp_ready !== 1'b1)
            $display("FAIL bp_release: got out_valid=%b smp_ready=%b expected 0/1", out_valid, smp_ready);
        else passed++;
        step();
        smp_valid = 1'b0;
        checks++;
        if ({pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2} !== {1'b1, CALC, 32'h11, 32'h22})
            $display("FAIL bp_next_cmd: got %b %h %h %h expected 1 %h 11 22",
                     pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, CALC);
        else passed++;
        repeat (2) step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h5678)
            $display("FAIL bp_next_out: got %b %h expected 1 00005678", out_valid, out_data);
        else passed++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        cfg_start = 1'b1;
        smp_valid = 1'b1;
        #1;
        checks++;
        if (smp_ready !== 1'b0) $display("FAIL sim_smp_ready: got %b expected 0", smp_ready);
        else passed++;
        step();
        cfg_start = 1'b0;
        smp_valid = 1'b0;
        checks++;
        if ({coef_ready, coef_loaded, pcpi_valid} !== 3'b100)
            $display("FAIL sim_load: got %b expected 100", {coef_ready, coef_loaded, pcpi_valid});
        else passed++;
    endtask

    task automatic test_reset_mid_load();
        int cyc;
        feed_coefs(5, cyc);
        checks++;
        if ({pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2} !== {1'b1, LOADH, 32'd5, 32'd1})
            $display("FAIL mid_cmd5: got %b %h %h %h expected 1 %h 5 1",
                     pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, LOADH);
        else passed++;
        resetn = 1'b1;
        step();
        resetn = 1'b0;
        checks++;
        if ({pcpi_valid, out_valid, coef_loaded, err, coef_ready} !== 5'b0)
            $display("FAIL mid_reset_flags: got %b expected 00000",
                     {pcpi_valid, out_valid, coef_loaded, err, coef_ready});
        else passed++;
        checks++;
        if ({pcpi_insn, pcpi_rs1, pcpi_rs2, out_data} !== 128'b0)
            $display("FAIL mid_reset_words: got %h expected 0", {pcpi_insn, pcpi_rs1, pcpi_rs2, out_data});
        else passed++;
        do_load("reload");
    endtask

    task automatic test_timeout();
        int ok_cnt;
        model_en  = 1'b0;
        smp_rs1   = 32'h99;
        smp_rs2   = 32'h98;
        smp_valid = 1'b1;
        #1;
        checks++;
        if (smp_ready !== 1'b1) $display("FAIL to_accept: got %b expected 1", smp_ready);
        else passed++;
        step();
        smp_valid = 1'b0;
        ok_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (pcpi_valid && !err) ok_cnt++;
            step();
        end
        checks++;
        if (ok_cnt !== 15) $display("FAIL to_cmd_cycles: got %0d expected 15", ok_cnt);
        else passed++;
        checks++;
        if ({err, pcpi_valid, smp_ready, coef_ready} !== 4'b1000)
            $display("FAIL to_err: got %b expected 1000", {err, pcpi_valid, smp_ready, coef_ready});
        else passed++;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        repeat (3) step();
        checks++;
        if ({err, coef_ready, coef_loaded, pcpi_valid} !== 4'b1010)
            $display("FAIL to_cfg_ignored: got %b expected 1010", {err, coef_ready, coef_loaded, pcpi_valid});
        else passed++;
        model_en = 1'b1;
        resetn   = 1'b1;
        step();
        resetn = 1'b0;
        checks++;
        if (err !== 1'b0 || coef_loaded !== 1'b0)
            $display("FAIL to_reset: got err=%b loaded=%b expected 0/0", err, coef_loaded);
        else passed++;
    endtask

    initial begin
        resetn     = 1'b1;
        cfg_start  = 1'b0;
        run_en     = 1'b0;
        coef_valid = 1'b0;
        coef_data  = '0;
        smp_valid  = 1'b0;
        smp_rs1    = '0;
        smp_rs2    = '0;
        out_ready  = 1'b0;
        model_en   = 1'b1;
        model_rd   = '0;
        @(negedge clk);
        test_reset();
        test_load();
        test_sample();
        test_backpressure();
        test_simultaneous();
        test_reset_mid_load();
        test_timeout();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", passed, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 Parameter N, default 8: analog states; LOADH index range 0..N-1.
REQ-002 Parameter K, default 256: coefficients per analog state.
REQ-003 Parameter TIMEOUT, default 15: maximum CMD cycles to wait for pcpi_ready.
REQ-004 clk  in  1  the single clock; all logic on its rising edge.
REQ-005 resetn  in  1  synchronous, active-high reset (1 = reset).
REQ-006 cfg_start  in  1  single-cycle request to (re)load all N*K coefficients.
REQ-007 run_en  in  1  level; permits sample processing.
REQ-008 coef_valid / coef_ready / coef_data  in / out / in  1/1/32  coefficient stream.
REQ-009 smp_valid / smp_ready / smp_rs1 / smp_rs2  in / out / in / in  1/1/32/32  packed control-bit words.
REQ-010 out_valid / out_ready / out_data  out / in / out  1/1/32  estimated sample output.
REQ-011 pcpi_valid, pcpi_insn[31:0], pcpi_rs1[31:0], pcpi_rs2[31:0]  out: command to the accelerator.
REQ-012 pcpi_ready, pcpi_wr, pcpi_rd[31:0]  in: accelerator response.
REQ-013 coef_loaded  out  1  all N*K coefficients written since the last cfg_start.
REQ-014 err  out  1  sticky protocol/timeout error.

Function
REQ-015 States SHALL be IDLE, LOAD, CMD, GAP, ERR.
REQ-016 Instruction words SHALL be: LOADH 32'h0000_3027, CALCULATE 32'h0000_2027.
REQ-017 IDLE, cfg_start=1: next LOAD; clear as_idx and k_idx; coef_loaded<=0. cfg_start wins over a pending sample.
REQ-018 IDLE, no cfg_start: smp_ready=1 combinationally iff coef_loaded && run_en && !out_valid. On handshake, latch smp_rs1/smp_rs2 into pcpi_rs1/pcpi_rs2, set insn=CALCULATE, next CMD.
REQ-019 LOAD: coef_ready=1. On handshake, set pcpi_rs1=coef_data, pcpi_rs2={28'b0,as_idx[3:0]}, insn=LOADH, next CMD.
REQ-020 coef_ready and smp_ready SHALL be 0 in every state other than those in REQ-018 and REQ-019.
REQ-021 CMD: pcpi_valid=1; insn, rs1 and rs2 SHALL stay stable until the cycle pcpi_ready=1.
REQ-022 CMD with pcpi_ready=1 on CALCULATE: pcpi_wr=1 captures pcpi_rd into out_data; out_valid<=1; next GAP. If pcpi_wr=0, next ERR.
REQ-023 CMD with pcpi_ready=1 on LOADH: advance k_idx. On wrap K-1->0, increment as_idx. Next GAP.
REQ-024 GAP: pcpi_valid=0 for exactly one cycle (accelerator returns to idle).
REQ-025 GAP exit: if a load is in progress and the coefficient just written had as_idx=N-1 and k_idx=K-1, set coef_loaded<=1 and go to IDLE. Otherwise, if loading, go to LOAD; else go to IDLE.
REQ-026 Timeout counter: cleared on CMD entry; increments each CMD cycle without pcpi_ready. Reaching TIMEOUT -> ERR.
REQ-027 ERR: err=1, pcpi_valid=0, all ready outputs 0. Only reset exits ERR; cfg_start is ignored.
REQ-028 cfg_start outside IDLE SHALL be ignored (not queued).
REQ-029 out_valid SHALL hold with out_data stable until out_ready=1; it clears on that cycle. A single output entry exists; no overwrite.
REQ-030 Latency: sample handshake at cycle t -> pcpi_valid in t+1..t+2 with a 2-cycle accelerator -> out_valid at t+3 -> IDLE at t+4. Peak rate 1 sample per 4 cycles.
REQ-031 run_en deassertion SHALL NOT abort an issued command; only new accepts stop.

Reset
REQ-032 With resetn=1 at an edge: state=IDLE, pcpi_valid=0, pcpi_insn/rs1/rs2=0, out_valid=0, out_data=0, coef_loaded=0, err=0, counters=0.
REQ-033 Reset mid-load or mid-command SHALL abandon the operation. pcpi_valid SHALL be 0 in the cycle after the reset edge.

Verification (N=3, K=4, TIMEOUT=15, accelerator model asserts ready on the 2nd valid cycle)
REQ-034 Load: cfg_start, then 12 coefficients 1..12 with coef_valid held high -> 12 LOADH commands, rs2 sequence 0x0 x4, 0x1 x4, 0x2 x4; coef_loaded=1 after the 12th GAP; ~48 cycles total.
REQ-035 Sample: smp_rs1=0x155, smp_rs2=0x2AA, model pcpi_rd=0x1234 -> CALCULATE with those operands; out_data=0x1234, out_valid at t+3.
REQ-036 Backpressure: out_ready=0 for 10 cycles -> smp_ready=0 throughout; out_data holds 0x1234; next sample accepted the cycle after the out handshake.
REQ-037 Timeout: model never asserts ready -> err=1 after 15 CMD cycles; pcpi_valid=0; cfg_start ignored until reset.
REQ-038 Reset during the 5th LOADH -> all outputs at reset values. A new cfg_start restarts from as_idx=0, k_idx=0.
REQ-039 Simultaneous cfg_start and smp_valid in IDLE with coef_loaded=1 -> LOAD entered, smp_ready=0, coef_loaded cleared.
